mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one pipelined 32x32 unsigned multiplier among N_REQ requesters in the matrix-multiplier datapath.
- Each cycle, a round-robin arbiter grants at most one valid request and drives its operands to the multiplier.
- A tag pipeline matched to the multiplier depth carries each operation's requester ID to the result, so the product returns to the requester that issued it.
- Sits between the row/column operand fetch units and the multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 6, edges from the multiplier sampling mul_a/mul_b to mul_result holding that product; must equal the integrated multiplier's pipeline depth (>=1).
- IDW, 2, requester-ID width, = ceil(log2(N_REQ)), minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- hold  in  1  when high, no new grants; in-flight operations drain normally.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ*32  operand A; requester i uses bits [32i+31:32i].
- req_b  in  N_REQ*32  operand B, same packing as req_a.
- req_ready  out  N_REQ  one-hot-or-zero grant.
- mul_a  out  32  operand A to the multiplier.
- mul_b  out  32  operand B to the multiplier.
- mul_result  in  64  product from the multiplier.
- rsp_valid  out  N_REQ  one-hot-or-zero result strobe, registered.
- rsp_data  out  64  product, registered.
- rsp_id  out  IDW  requester index of rsp_data, registered.
- inflight  out  4  operations accepted but not yet returned (0..MUL_LAT+1).
- idle  out  1  high when inflight==0 and no handshake is occurring this cycle.

Behaviour:
- Reset (rst high at an edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, inflight=0.
  - Tag pipeline cleared; round-robin pointer=0 (requester 0 has highest priority).
  - Results still inside the multiplier are discarded; no rsp_valid is produced for them.
  - While rst is high, req_ready=0.
- Arbitration (combinational):
  - Search begins at index ptr, increasing with wrap to 0.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other ready bits are 0.
  - hold=1 or rst=1 forces req_ready=0.
  - req_ready may depend on req_valid.
  - A requester with valid high and ready low must keep req_a/req_b stable and keep valid asserted.
- Handshake: req_valid[i] & req_ready[i] in cycle c.
  - mul_a/mul_b are combinational muxes of the granted requester's operands in cycle c, so the multiplier samples them at the end of c.
  - With no grant, mul_a and mul_b are driven to 0.
  - ptr <= (i+1) mod N_REQ at the end of c.
  - ptr does not change in cycles without a handshake.
- Tag pipeline:
  - MUL_LAT stages of {valid, id}.
  - Stage 0 loads {handshake, i} every edge; each other stage shifts every edge. There is no stall, because the multiplier cannot be stalled.
  - In cycle c+MUL_LAT, the last stage is valid and mul_result is the product from cycle c.
- Response:
  - At the end of cycle c+MUL_LAT, rsp_data<=mul_result, rsp_id<=id and rsp_valid<=onehot(id), all from the last tag stage.
  - rsp_valid is high only in cycle c+MUL_LAT+1. Total latency is MUL_LAT+1 cycles.
  - When the last tag stage is invalid, rsp_valid<=0; rsp_data and rsp_id hold their previous values.
  - Responses cannot be back-pressured; requesters must always accept them.
- inflight counter:
  - +1 on a handshake; -1 in cycles where rsp_valid is high.
  - Both in the same cycle: unchanged.
  - Never exceeds MUL_LAT+1, because there is at most one issue per cycle.
- Throughput: one operation per cycle sustained. With all requesters valid, grants rotate 0,1,..,N_REQ-1,0,...
- Products are unsigned, full 64-bit. There is no truncation or saturation.
- hold asserted mid-stream: grants stop that cycle, and already-issued operations return on schedule.
- A requester that drops valid before being granted loses its slot; this is not an error, and ptr is unaffected.

Test Plan:
1. Reset, then only requester 2 valid with a=0xFFFFFFFF, b=0xFFFFFFFF at cycle 0:
   - req_ready=0b0100 in cycle 0.
   - rsp_valid=0b0100, rsp_id=2, rsp_data=0xFFFFFFFE00000001 in cycle 7 only.
   - inflight goes 1..1 then back to 0.
2. All four requesters valid continuously, requester i with operands a=i+1, b=0x10:
   - Grants 0,1,2,3,0,... on consecutive cycles.
   - Responses from cycle 7 onward carry rsp_data=0x10,0x20,0x30,0x40, one per cycle, with matching rsp_id.
   - inflight saturates at 7.
3. Fairness after partial grant:
   - Requester 1 granted; then requesters 0 and 3 valid together.
   - Requester 3 is granted first, then requester 0.
4. hold=1 in cycles 2..5 during a continuous 3-requester stream:
   - req_ready=0 in cycles 2..5.
   - The products issued in cycles 0 and 1 return in cycles 7 and 8.
   - Issue resumes in cycle 6 from the correct pointer.
5. rst pulsed in cycle 4 with 4 operations in flight:
   - No rsp_valid is seen for those operations.
   - inflight=0 and idle=1 after reset.
   - A new request issued after reset returns normally at +7.
6. Simultaneous issue and retire at steady state: inflight holds constant, and idle stays low until the final response has passed.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one pipelined 32x32 unsigned multiplier among N_REQ
// requesters, with a tag pipeline steering each product back to its issuer.
module mul_share_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MUL_LAT = 6,
    parameter int unsigned IDW     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 hold_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ*32-1:0]  req_a_i,
    input  logic [N_REQ*32-1:0]  req_b_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [31:0]          mul_a_o,
    output logic [31:0]          mul_b_o,
    input  logic [63:0]          mul_result_i,
    output logic [N_REQ-1:0]     rsp_valid_o,
    output logic [63:0]          rsp_data_o,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [3:0]           inflight_o,
    output logic                 idle_o
);

    localparam logic [IDW:0]   NReqW  = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] LastId = IDW'(N_REQ - 1);

    logic [31:0]        a_arr [N_REQ];
    logic [31:0]        b_arr [N_REQ];
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW:0]       idx;
    logic               gnt_vld;
    logic [IDW-1:0]     gnt_id;
    logic               hs;
    logic [MUL_LAT-1:0] tag_vld_q;
    logic [IDW-1:0]     tag_id_q [MUL_LAT];
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [63:0]        rsp_data_q, rsp_data_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [3:0]         inflight_q, inflight_d;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a_i[32*g +: 32];
        assign b_arr[g] = req_b_i[32*g +: 32];
    end

    // Rotating priority search starting at ptr_q, wrapping past N_REQ-1.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (idx >= NReqW) begin
                idx = idx - NReqW;
            end
            if (!gnt_vld && req_valid_i[idx[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx[IDW-1:0];
            end
        end
    end

    assign hs = gnt_vld & ~hold_i & ~rst_i;

    always_comb begin
        req_ready_o         = '0;
        req_ready_o[gnt_id] = hs;
        mul_a_o             = hs ? a_arr[gnt_id] : 32'd0;
        mul_b_o             = hs ? b_arr[gnt_id] : 32'd0;
        ptr_d               = ptr_q;
        if (hs) begin
            ptr_d = (gnt_id == LastId) ? '0 : gnt_id + 1'b1;
        end
    end

    // The multiplier cannot stall, so the last tag stage alone decides the response.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (tag_vld_q[MUL_LAT-1]) begin
            rsp_valid_d[tag_id_q[MUL_LAT-1]] = 1'b1;
            rsp_data_d                       = mul_result_i;
            rsp_id_d                         = tag_id_q[MUL_LAT-1];
        end
        inflight_d = inflight_q + 4'(hs) - 4'(|rsp_valid_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            tag_vld_q   <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            inflight_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q[0] <= hs;
            tag_id_q[0]  <= gnt_id;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            inflight_q  <= inflight_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign inflight_o  = inflight_q;
    assign idle_o      = (inflight_q == 4'd0) && !hs;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural 6-stage multiplier alongside.
module tb_mul_share_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned MUL_LAT = 6;
    localparam int unsigned IDW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold;
    logic [3:0]        req_valid;
    logic [127:0]      req_a;
    logic [127:0]      req_b;
    logic [3:0]        req_ready;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [63:0]       mul_result;
    logic [3:0]        rsp_valid;
    logic [63:0]       rsp_data;
    logic [1:0]        rsp_id;
    logic [3:0]        inflight;
    logic              idle;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]  valid;
        logic        hold;
        logic [3:0]  ready;
        logic [3:0]  rsp_valid;
        logic [1:0]  rsp_id;
        logic [63:0] rsp_data;
        logic [3:0]  inflight;
    } vec_t;

    vec_t tbl_rr [12];
    vec_t tbl_hold [14];

    mul_share_arbiter #(
        .N_REQ   (N_REQ),
        .MUL_LAT (MUL_LAT),
        .IDW     (IDW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .hold_i       (hold),
        .req_valid_i  (req_valid),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_ready_o  (req_ready),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_result_i (mul_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .rsp_id_o     (rsp_id),
        .inflight_o   (inflight),
        .idle_o       (idle)
    );

    always #5 clk = ~clk;

    // Multiplier model: samples operands at an edge, product visible MUL_LAT edges later.
    logic [63:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
        for (int i = 1; i < MUL_LAT; i++) begin
            mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_result = mpipe[MUL_LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 4'hF;
        #3;
        check("ready_during_rst", 64'(req_ready), 64'h0);
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'h0;
        #3;
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_rsp_id", 64'(rsp_id), 64'h0);
        check("rst_inflight", 64'(inflight), 64'h0);
        check("rst_idle", 64'(idle), 64'h1);
        next_cycle();
    endtask

    task automatic run_row(input string tag, input int c, input vec_t v);
        req_valid = v.valid;
        hold      = v.hold;
        #3;
        check($sformatf("%s_c%0d_ready", tag, c), 64'(req_ready), 64'(v.ready));
        check($sformatf("%s_c%0d_rsp_valid", tag, c), 64'(rsp_valid), 64'(v.rsp_valid));
        check($sformatf("%s_c%0d_rsp_id", tag, c), 64'(rsp_id), 64'(v.rsp_id));
        check($sformatf("%s_c%0d_rsp_data", tag, c), rsp_data, v.rsp_data);
        check($sformatf("%s_c%0d_inflight", tag, c), 64'(inflight), 64'(v.inflight));
        next_cycle();
    endtask

    initial begin
        logic [3:0] exp_rv;

        // All four valid: grants rotate, products i+1 times 0x10 come back from cycle 7.
        tbl_rr[0]  = '{4'hF, 1'b0, 4'b0001, 4'b0000, 2'd0, 64'h0,  4'd0};
        tbl_rr[1]  = '{4'hF, 1'b0, 4'b0010, 4'b0000, 2'd0, 64'h0,  4'd1};
        tbl_rr[2]  = '{4'hF, 1'b0, 4'b0100, 4'b0000, 2'd0, 64'h0,  4'd2};
        tbl_rr[3]  = '{4'hF, 1'b0, 4'b1000, 4'b0000, 2'd0, 64'h0,  4'd3};
        tbl_rr[4]  = '{4'hF, 1'b0, 4'b0001, 4'b0000, 2'd0, 64'h0,  4'd4};
        tbl_rr[5]  = '{4'hF, 1'b0, 4'b0010, 4'b0000, 2'd0, 64'h0,  4'd5};
        tbl_rr[6]  = '{4'hF, 1'b0, 4'b0100, 4'b0000, 2'd0, 64'h0,  4'd6};
        tbl_rr[7]  = '{4'hF, 1'b0, 4'b1000, 4'b0001, 2'd0, 64'h10, 4'd7};
        tbl_rr[8]  = '{4'hF, 1'b0, 4'b0001, 4'b0010, 2'd1, 64'h20, 4'd7};
        tbl_rr[9]  = '{4'hF, 1'b0, 4'b0010, 4'b0100, 2'd2, 64'h30, 4'd7};
        tbl_rr[10] = '{4'hF, 1'b0, 4'b0100, 4'b1000, 2'd3, 64'h40, 4'd7};
        tbl_rr[11] = '{4'hF, 1'b0, 4'b1000, 4'b0001, 2'd0, 64'h10, 4'd7};

        // Three requesters, hold in cycles 2..5.
        tbl_hold[0]  = '{4'h7, 1'b0, 4'b0001, 4'b0000, 2'd0, 64'h0,  4'd0};
        tbl_hold[1]  = '{4'h7, 1'b0, 4'b0010, 4'b0000, 2'd0, 64'h0,  4'd1};
        tbl_hold[2]  = '{4'h7, 1'b1, 4'b0000, 4'b0000, 2'd0, 64'h0,  4'd2};
        tbl_hold[3]  = '{4'h7, 1'b1, 4'b0000, 4'b0000, 2'd0, 64'h0,  4'd2};
        tbl_hold[4]  = '{4'h7, 1'b1, 4'b0000, 4'b0000, 2'd0, 64'h0,  4'd2};
        tbl_hold[5]  = '{4'h7, 1'b1, 4'b0000, 4'b0000, 2'd0, 64'h0,  4'd2};
        tbl_hold[6]  = '{4'h7, 1'b0, 4'b0100, 4'b0000, 2'd0, 64'h0,  4'd2};
        tbl_hold[7]  = '{4'h7, 1'b0, 4'b0001, 4'b0001, 2'd0, 64'h10, 4'd3};
        tbl_hold[8]  = '{4'h7, 1'b0, 4'b0010, 4'b0010, 2'd1, 64'h20, 4'd3};
        tbl_hold[9]  = '{4'h7, 1'b0, 4'b0100, 4'b0000, 2'd1, 64'h20, 4'd3};
        tbl_hold[10] = '{4'h7, 1'b0, 4'b0001, 4'b0000, 2'd1, 64'h20, 4'd4};
        tbl_hold[11] = '{4'h7, 1'b0, 4'b0010, 4'b0000, 2'd1, 64'h20, 4'd5};
        tbl_hold[12] = '{4'h7, 1'b0, 4'b0100, 4'b0000, 2'd1, 64'h20, 4'd6};
        tbl_hold[13] = '{4'h7, 1'b0, 4'b0001, 4'b0100, 2'd2, 64'h30, 4'd7};

        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 4'h0;
        req_a     = {32'd4, 32'd3, 32'd2, 32'd1};
        req_b     = {4{32'h10}};

        // Single max-operand request from requester 2.
        do_reset();
        req_a[95:64] = 32'hFFFF_FFFF;
        req_b[95:64] = 32'hFFFF_FFFF;
        req_valid    = 4'b0100;
        #3;
        check("t1_ready", 64'(req_ready), 64'h4);
        check("t1_mul_a", 64'(mul_a), 64'hFFFF_FFFF);
        check("t1_mul_b", 64'(mul_b), 64'hFFFF_FFFF);
        check("t1_idle_hs", 64'(idle), 64'h0);
        next_cycle();
        req_valid = 4'h0;
        for (int c = 1; c <= 8; c++) begin
            #3;
            if (c == 1) begin
                check("t1_mul_a_nogrant", 64'(mul_a), 64'h0);
            end
            exp_rv = (c == 7) ? 4'b0100 : 4'b0000;
            check($sformatf("t1_c%0d_rsp_valid", c), 64'(rsp_valid), 64'(exp_rv));
            check($sformatf("t1_c%0d_inflight", c), 64'(inflight), (c <= 7) ? 64'h1 : 64'h0);
            check($sformatf("t1_c%0d_idle", c), 64'(idle), (c == 8) ? 64'h1 : 64'h0);
            if (c == 7) begin
                check("t1_rsp_data", rsp_data, 64'hFFFF_FFFE_0000_0001);
                check("t1_rsp_id", 64'(rsp_id), 64'h2);
            end
            next_cycle();
        end
        req_a = {32'd4, 32'd3, 32'd2, 32'd1};
        req_b = {4{32'h10}};

        // Full round-robin stream, then drain with steady issue/retire before it.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            run_row("rr", c, tbl_rr[c]);
        end
        req_valid = 4'h0;
        for (int c = 12; c <= 19; c++) begin
            #3;
            exp_rv = (c <= 18) ? (4'b0001 << ((c - 7) % 4)) : 4'b0000;
            check($sformatf("drain_c%0d_rsp_valid", c), 64'(rsp_valid), 64'(exp_rv));
            check($sformatf("drain_c%0d_inflight", c), 64'(inflight), 64'(19 - c));
            check($sformatf("drain_c%0d_idle", c), 64'(idle), (c == 19) ? 64'h1 : 64'h0);
            next_cycle();
        end

        // Fairness after a partial grant, and a dropped request leaves ptr alone.
        do_reset();
        req_valid = 4'b0010;
        #3;
        check("t3_first", 64'(req_ready), 64'h2);
        next_cycle();
        req_valid = 4'b1001;
        #3;
        check("t3_second", 64'(req_ready), 64'h8);
        next_cycle();
        req_valid = 4'b0001;
        #3;
        check("t3_third", 64'(req_ready), 64'h1);
        next_cycle();
        req_valid = 4'b0000;
        #3;
        check("t3_none", 64'(req_ready), 64'h0);
        next_cycle();
        req_valid = 4'b1111;
        #3;
        check("t3_after_gap", 64'(req_ready), 64'h2);
        next_cycle();
        req_valid = 4'b0000;

        // hold mid-stream.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            run_row("hold", c, tbl_hold[c]);
        end
        hold      = 1'b0;
        req_valid = 4'h0;

        // Reset with operations in flight discards them; a fresh request returns normally.
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c < 4; c++) begin
            #3;
            check($sformatf("t5_c%0d_ready", c), 64'(req_ready), 64'(4'b0001 << c));
            next_cycle();
        end
        rst = 1'b1;
        #3;
        check("t5_ready_in_rst", 64'(req_ready), 64'h0);
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'h0;
        #3;
        check("t5_inflight_after", 64'(inflight), 64'h0);
        check("t5_idle_after", 64'(idle), 64'h1);
        check("t5_rsp_valid_after", 64'(rsp_valid), 64'h0);
        next_cycle();
        req_valid = 4'b0010;
        #3;
        check("t5_new_ready", 64'(req_ready), 64'h2);
        next_cycle();
        req_valid = 4'h0;
        for (int c = 7; c <= 13; c++) begin
            #3;
            exp_rv = (c == 13) ? 4'b0010 : 4'b0000;
            check($sformatf("t5_c%0d_rsp_valid", c), 64'(rsp_valid), 64'(exp_rv));
            if (c == 13) begin
                check("t5_rsp_data", rsp_data, 64'h20);
                check("t5_rsp_id", 64'(rsp_id), 64'h1);
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
